// File: rtl/pipe_hazard_controller.sv
// Purpose: RV32I 5-stage control path (decode in D, control piped D->E->M->W) with hazard unit and forwarding selects.
// Latency: one cycle per stage D->E->M->W; hazard/forward/pcsrc outputs are combinational from stage registers and D inputs.
// Backpressure: stall_i freezes every stage register; a load-use (or RAW without forwarding) hazard holds F/D and bubbles E.
//
// Ports:
//   clk_i, rst_i (synchronous, active-high), stall_i (external freeze)
//   D-stage in : op_i, funct3_i, funct7b5_i, rs1D_i, rs2D_i, rdD_i; out immsrcD_o
//   E-stage in : zeroE_i, ltE_i, ltuE_i; out alusrcE_o, alucontrolE_o, resultsrcE_o, pcsrcE_o
//   M/W out    : memwriteM_o, regwriteM_o, resultsrcW_o, regwriteW_o
//   hazard out : stallF_o, stallD_o, flushD_o, flushE_o, forwardAE_o, forwardBE_o
// Build option: define FWD_EN for M/W->E forwarding (load-use stalls only); without it the
//   forward selects are tied to 00 and any RAW dependence on E or M stalls until the producer is in W.
module pipe_hazard_controller #(
  parameter int REG_AW   = 5,
  parameter int ALUCTL_W = 3,
  parameter int RESULT_W = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  input  logic [6:0]          op_i,
  input  logic [2:0]          funct3_i,
  input  logic                funct7b5_i,
  input  logic [REG_AW-1:0]   rs1D_i,
  input  logic [REG_AW-1:0]   rs2D_i,
  input  logic [REG_AW-1:0]   rdD_i,
  input  logic                zeroE_i,
  input  logic                ltE_i,
  input  logic                ltuE_i,
  output logic [1:0]          immsrcD_o,
  output logic                alusrcE_o,
  output logic [ALUCTL_W-1:0] alucontrolE_o,
  output logic [RESULT_W-1:0] resultsrcE_o,
  output logic                pcsrcE_o,
  output logic                memwriteM_o,
  output logic                regwriteM_o,
  output logic [RESULT_W-1:0] resultsrcW_o,
  output logic                regwriteW_o,
  output logic                stallF_o,
  output logic                stallD_o,
  output logic                flushD_o,
  output logic                flushE_o,
  output logic [1:0]          forwardAE_o,
  output logic [1:0]          forwardBE_o
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(3'b000);
  localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(3'b001);
  localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(3'b010);
  localparam logic [ALUCTL_W-1:0] ALU_OR  = ALUCTL_W'(3'b011);
  localparam logic [ALUCTL_W-1:0] ALU_SLT = ALUCTL_W'(3'b101);

  localparam logic [RESULT_W-1:0] RES_ALU = RESULT_W'(2'b00);
  localparam logic [RESULT_W-1:0] RES_MEM = RESULT_W'(2'b01);
  localparam logic [RESULT_W-1:0] RES_PC4 = RESULT_W'(2'b10);

  typedef struct packed {
    logic                regwrite;
    logic [RESULT_W-1:0] resultsrc;
    logic                memwrite;
    logic                jump;
    logic                branch;
    logic [ALUCTL_W-1:0] alucontrol;
    logic                alusrc;
    logic [2:0]          funct3;
`ifdef FWD_EN
    logic [REG_AW-1:0]   rs1;
    logic [REG_AW-1:0]   rs2;
`endif
    logic [REG_AW-1:0]   rd;
  } ex_t;

  typedef struct packed {
    logic                regwrite;
    logic [RESULT_W-1:0] resultsrc;
    logic                memwrite;
    logic [REG_AW-1:0]   rd;
  } mem_t;

  typedef struct packed {
    logic                regwrite;
    logic [RESULT_W-1:0] resultsrc;
`ifdef FWD_EN
    logic [REG_AW-1:0]   rd;
`endif
  } wb_t;

  ex_t  dec;
  ex_t  ex_d,  ex_q;
  mem_t mem_d, mem_q;
  wb_t  wb_d,  wb_q;
  logic [1:0] aluop;

  // Main + ALU decode. Unlisted opcodes leave every enable at 0 (a bubble).
  always_comb begin
    dec        = '0;
    aluop      = 2'b00;
    immsrcD_o  = 2'b00;
    dec.funct3 = funct3_i;
    dec.rd     = rdD_i;
`ifdef FWD_EN
    dec.rs1    = rs1D_i;
    dec.rs2    = rs2D_i;
`endif
    case (op_i)
      OP_LW:  begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.resultsrc = RES_MEM; end
      OP_SW:  begin immsrcD_o = 2'b01; dec.alusrc = 1'b1; dec.memwrite = 1'b1; end
      OP_R:   begin dec.regwrite = 1'b1; aluop = 2'b10; end
      OP_I:   begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; aluop = 2'b10; end
      OP_BR:  begin immsrcD_o = 2'b10; dec.branch = 1'b1; aluop = 2'b01; end
      OP_JAL: begin immsrcD_o = 2'b11; dec.regwrite = 1'b1; dec.jump = 1'b1; dec.resultsrc = RES_PC4; end
      default: ;
    endcase
    case (aluop)
      2'b01: dec.alucontrol = ALU_SUB;
      2'b10: begin
        case (funct3_i)
          // op_i[5] separates R-type from I-type: only R-type honours funct7b5 as sub.
          3'b000:  dec.alucontrol = (op_i[5] & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  dec.alucontrol = ALU_SLT;
          3'b110:  dec.alucontrol = ALU_OR;
          3'b111:  dec.alucontrol = ALU_AND;
          default: dec.alucontrol = ALU_ADD;
        endcase
      end
      default: dec.alucontrol = ALU_ADD;
    endcase
  end

  // Branch resolution in E.
  logic br_cond, pcsrc, hz_stall, flush_e;
  always_comb begin
    case (ex_q.funct3)
      3'b000:  br_cond = zeroE_i;
      3'b001:  br_cond = ~zeroE_i;
      3'b100:  br_cond = ltE_i;
      3'b101:  br_cond = ~ltE_i;
      3'b110:  br_cond = ltuE_i;
      3'b111:  br_cond = ~ltuE_i;
      default: br_cond = 1'b0;
    endcase
  end

  // Redirect is suppressed while frozen so it fires once, in the cycle the pipe moves again.
  assign pcsrc   = ((ex_q.branch & br_cond) | ex_q.jump) & ~stall_i & ~rst_i;
  assign flush_e = (hz_stall | pcsrc) & ~stall_i & ~rst_i;

`ifdef FWD_EN
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    if (mem_q.regwrite && (mem_q.rd != '0) && (mem_q.rd == rs)) return 2'b10;
    if (wb_q.regwrite && (wb_q.rd != '0) && (wb_q.rd == rs))    return 2'b01;
    return 2'b00;
  endfunction

  assign hz_stall = (ex_q.resultsrc == RES_MEM) && (ex_q.rd != '0) &&
                    ((ex_q.rd == rs1D_i) || (ex_q.rd == rs2D_i)) && !rst_i;
  assign forwardAE_o = rst_i ? 2'b00 : fwd_sel(ex_q.rs1);
  assign forwardBE_o = rst_i ? 2'b00 : fwd_sel(ex_q.rs2);
`else
  function automatic logic raw_dep(input logic [REG_AW-1:0] rs);
    // W is not checked: the register file writes before it reads.
    return (rs != '0) && ((ex_q.regwrite && (ex_q.rd == rs)) ||
                          (mem_q.regwrite && (mem_q.rd == rs)));
  endfunction

  assign hz_stall    = (raw_dep(rs1D_i) || raw_dep(rs2D_i)) && !rst_i;
  assign forwardAE_o = 2'b00;
  assign forwardBE_o = 2'b00;
`endif

  // stallD stays up alongside a taken branch; the datapath gives flushD priority at IF/ID.
  assign stallF_o = (stall_i | hz_stall) & ~rst_i;
  assign stallD_o = (stall_i | hz_stall) & ~rst_i;
  assign flushD_o = pcsrc;
  assign flushE_o = flush_e;
  assign pcsrcE_o = pcsrc;

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!stall_i) begin
      ex_d            = flush_e ? '0 : dec;
      mem_d.regwrite  = ex_q.regwrite;
      mem_d.resultsrc = ex_q.resultsrc;
      mem_d.memwrite  = ex_q.memwrite;
      mem_d.rd        = ex_q.rd;
      wb_d.regwrite   = mem_q.regwrite;
      wb_d.resultsrc  = mem_q.resultsrc;
`ifdef FWD_EN
      wb_d.rd         = mem_q.rd;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign alusrcE_o     = ex_q.alusrc;
  assign alucontrolE_o = ex_q.alucontrol;
  assign resultsrcE_o  = ex_q.resultsrc;
  assign memwriteM_o   = mem_q.memwrite;
  assign regwriteM_o   = mem_q.regwrite;
  assign resultsrcW_o  = wb_q.resultsrc;
  assign regwriteW_o   = wb_q.regwrite;

endmodule

// File: tb/tb_pipe_hazard_controller.sv
// Bench for pipe_hazard_controller: directed scenarios plus random instruction streams,
// compared every cycle with an instruction-level pipeline model (records in E/M/W).
module tb_pipe_hazard_controller;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
`ifdef FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, stall, f7, zero, lt, ltu;
  logic [6:0] op;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;

  logic [1:0] immsrcD_o, resultsrcE_o, resultsrcW_o, forwardAE_o, forwardBE_o;
  logic [2:0] alucontrolE_o;
  logic       alusrcE_o, pcsrcE_o, memwriteM_o, regwriteM_o, regwriteW_o;
  logic       stallF_o, stallD_o, flushD_o, flushE_o;

  pipe_hazard_controller dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall),
    .op_i(op), .funct3_i(f3), .funct7b5_i(f7),
    .rs1D_i(rs1), .rs2D_i(rs2), .rdD_i(rd),
    .zeroE_i(zero), .ltE_i(lt), .ltuE_i(ltu),
    .immsrcD_o(immsrcD_o), .alusrcE_o(alusrcE_o), .alucontrolE_o(alucontrolE_o),
    .resultsrcE_o(resultsrcE_o), .pcsrcE_o(pcsrcE_o), .memwriteM_o(memwriteM_o),
    .regwriteM_o(regwriteM_o), .resultsrcW_o(resultsrcW_o), .regwriteW_o(regwriteW_o),
    .stallF_o(stallF_o), .stallD_o(stallD_o), .flushD_o(flushD_o), .flushE_o(flushE_o),
    .forwardAE_o(forwardAE_o), .forwardBE_o(forwardBE_o)
  );

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [4:0] rs1, rs2, rd;
  } ins_t;

  ins_t m_e, m_m, m_w;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction semantics straight from the ISA table.
  function automatic bit wr(input ins_t i);
    return i.op == LW || i.op == RT || i.op == IT || i.op == JAL;
  endfunction
  function automatic logic [1:0] rsrc(input ins_t i);
    return (i.op == LW) ? 2'd1 : (i.op == JAL) ? 2'd2 : 2'd0;
  endfunction
  function automatic bit asrc(input ins_t i);
    return i.op == LW || i.op == SW || i.op == IT;
  endfunction
  function automatic logic [1:0] imm(input logic [6:0] o);
    return (o == SW) ? 2'd1 : (o == BR) ? 2'd2 : (o == JAL) ? 2'd3 : 2'd0;
  endfunction
  function automatic logic [2:0] aluc(input ins_t i);
    if (i.op == BR) return 3'd1;
    if (i.op != RT && i.op != IT) return 3'd0;
    if (i.f3 == 3'b000) return (i.op == RT && i.f7) ? 3'd1 : 3'd0;
    if (i.f3 == 3'b010) return 3'd5;
    if (i.f3 == 3'b110) return 3'd3;
    if (i.f3 == 3'b111) return 3'd2;
    return 3'd0;
  endfunction
  function automatic bit taken(input ins_t i);
    if (i.op == JAL) return 1'b1;
    if (i.op != BR) return 1'b0;
    case (i.f3)
      3'b000: return zero;
      3'b001: return !zero;
      3'b100: return lt;
      3'b101: return !lt;
      3'b110: return ltu;
      3'b111: return !ltu;
      default: return 1'b0;
    endcase
  endfunction
  function automatic bit dep(input logic [4:0] r);
    return r != 0 && ((wr(m_e) && m_e.rd == r) || (wr(m_m) && m_m.rd == r));
  endfunction
  function automatic bit m_hz();
    if (FWD) return m_e.op == LW && m_e.rd != 0 && (m_e.rd == rs1 || m_e.rd == rs2);
    return dep(rs1) || dep(rs2);
  endfunction
  function automatic logic [1:0] fsel(input logic [4:0] r);
    if (wr(m_m) && m_m.rd != 0 && m_m.rd == r) return 2'd2;
    if (wr(m_w) && m_w.rd != 0 && m_w.rd == r) return 2'd1;
    return 2'd0;
  endfunction

  task automatic check_all();
    bit hz, pc;
    logic [1:0] fa, fb;
    hz = !rst && m_hz();
    pc = !rst && !stall && taken(m_e);
    fa = (FWD && !rst) ? fsel(m_e.rs1) : 2'd0;
    fb = (FWD && !rst) ? fsel(m_e.rs2) : 2'd0;
    chk("immsrcD", immsrcD_o, imm(op));
    chk("alusrcE", alusrcE_o, asrc(m_e));
    chk("alucontrolE", alucontrolE_o, aluc(m_e));
    chk("resultsrcE", resultsrcE_o, rsrc(m_e));
    chk("pcsrcE", pcsrcE_o, pc);
    chk("memwriteM", memwriteM_o, m_m.op == SW);
    chk("regwriteM", regwriteM_o, wr(m_m));
    chk("resultsrcW", resultsrcW_o, rsrc(m_w));
    chk("regwriteW", regwriteW_o, wr(m_w));
    chk("stallF", stallF_o, !rst && (stall || hz));
    chk("stallD", stallD_o, !rst && (stall || hz));
    chk("flushD", flushD_o, pc);
    chk("flushE", flushE_o, !rst && !stall && (hz || pc));
    chk("forwardAE", forwardAE_o, fa);
    chk("forwardBE", forwardBE_o, fb);
  endtask

  task automatic tick();
    bit hz, pc;
    ins_t d;
    hz = m_hz();
    pc = !stall && taken(m_e);
    d.op = op; d.f3 = f3; d.f7 = f7; d.rs1 = rs1; d.rs2 = rs2; d.rd = rd;
    @(posedge clk);
    if (rst) begin
      m_e = '0; m_m = '0; m_w = '0;
    end else if (!stall) begin
      m_w = m_m;
      m_m = m_e;
      m_e = (hz || pc) ? ins_t'('0) : d;
    end
    #1;
  endtask

  task automatic set_ins(input logic [6:0] o, input logic [2:0] g, input logic s7,
                         input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    op = o; f3 = g; f7 = s7; rs1 = a; rs2 = b; rd = d;
  endtask

  task automatic settle_check();
    #1;
    check_all();
  endtask

  task automatic nop();
    set_ins(IT, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    m_e = '0; m_m = '0; m_w = '0;
    rst = 1'b1; stall = 1'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    set_ins(LW, 3'b010, 1'b0, 5'd1, 5'd0, 5'd5);

    // Reset held two cycles with lw on the D inputs.
    tick(); tick();
    settle_check();
    chk("rst_all_outputs",
        {immsrcD_o, alusrcE_o, alucontrolE_o, resultsrcE_o, pcsrcE_o, memwriteM_o, regwriteM_o,
         resultsrcW_o, regwriteW_o, stallF_o, stallD_o, flushD_o, flushE_o, forwardAE_o, forwardBE_o}, 0);

    // lw x5,0(x0) then add x6,x5,x5.
    rst = 1'b0;
    set_ins(LW, 3'b010, 1'b0, 5'd0, 5'd0, 5'd5);
    settle_check();
    tick();
    set_ins(RT, 3'b000, 1'b0, 5'd5, 5'd5, 5'd6);
    settle_check();
    chk("lw_reaches_E", resultsrcE_o, 2'd1);
    chk("lwuse_stallF", stallF_o, 1'b1);
    chk("lwuse_stallD", stallD_o, 1'b1);
    chk("lwuse_flushE", flushE_o, 1'b1);
    tick();
    settle_check();
`ifdef FWD_EN
    chk("lwuse_one_cycle", stallF_o, 1'b0);
    tick();
    nop();
    settle_check();
    chk("lwuse_fwdA", forwardAE_o, 2'd1);
    chk("lwuse_fwdB", forwardBE_o, 2'd1);
`else
    chk("raw_lw_M_stall", stallF_o, 1'b1);
    tick();
    settle_check();
    chk("raw_lw_W_release", stallF_o, 1'b0);
    tick();
    nop();
    settle_check();
    chk("nofwd_fwdA", forwardAE_o, 2'd0);
`endif
    tick(); tick(); tick();

    // bne taken (zero=0) then not taken (zero=1).
    set_ins(BR, 3'b001, 1'b0, 5'd1, 5'd2, 5'd0);
    zero = 1'b0;
    settle_check();
    tick();
    nop();
    settle_check();
    chk("bne_taken_pcsrc", pcsrcE_o, 1'b1);
    chk("bne_taken_flushD", flushD_o, 1'b1);
    chk("bne_taken_flushE", flushE_o, 1'b1);
    tick();
    set_ins(BR, 3'b001, 1'b0, 5'd1, 5'd2, 5'd0);
    settle_check();
    tick();
    nop();
    zero = 1'b1;
    settle_check();
    chk("bne_not_pcsrc", pcsrcE_o, 1'b0);
    chk("bne_not_flushD", flushD_o, 1'b0);
    chk("bne_not_flushE", flushE_o, 1'b0);
    tick();

    // beq taken while externally stalled for three cycles.
    set_ins(BR, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0);
    settle_check();
    tick();
    nop();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle_check();
      chk("stall_pcsrc", pcsrcE_o, 1'b0);
      chk("stall_flushD", flushD_o, 1'b0);
      chk("stall_flushE", flushE_o, 1'b0);
      chk("stall_stallF", stallF_o, 1'b1);
      chk("stall_frozen_aluctl", alucontrolE_o, 3'd1);
      tick();
    end
    stall = 1'b0;
    settle_check();
    chk("release_pcsrc", pcsrcE_o, 1'b1);
    chk("release_flushD", flushD_o, 1'b1);
    chk("release_flushE", flushE_o, 1'b1);
    tick();
    zero = 1'b0;

`ifdef FWD_EN
    // add x3,x1,x2 ; sub x4,x3,x1 back-to-back, then with one nop between.
    set_ins(RT, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3);
    settle_check();
    tick();
    set_ins(RT, 3'b000, 1'b1, 5'd3, 5'd1, 5'd4);
    settle_check();
    chk("fwdM_no_stall", stallF_o, 1'b0);
    tick();
    nop();
    settle_check();
    chk("fwdM_sel", forwardAE_o, 2'd2);
    tick();
    set_ins(RT, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3);
    tick();
    nop();
    tick();
    set_ins(RT, 3'b000, 1'b1, 5'd3, 5'd1, 5'd4);
    tick();
    nop();
    settle_check();
    chk("fwdW_sel", forwardAE_o, 2'd1);
    tick();
`else
    // add x3,x1,x2 then or x7,x3,x0: two stall cycles, forwards stay 00.
    set_ins(RT, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3);
    settle_check();
    tick();
    set_ins(RT, 3'b110, 1'b0, 5'd3, 5'd0, 5'd7);
    settle_check();
    chk("raw_stallF_1", stallF_o, 1'b1);
    chk("raw_stallD_1", stallD_o, 1'b1);
    tick();
    settle_check();
    chk("raw_stallF_2", stallF_o, 1'b1);
    tick();
    settle_check();
    chk("raw_stall_done", stallF_o, 1'b0);
    chk("raw_fwd_zero", forwardAE_o, 2'd0);
    tick();
`endif

    // Random instruction streams with stalls and occasional reset.
    for (int n = 0; n < 1500; n++) begin
      logic [6:0] o;
      case ($urandom_range(0, 7))
        0: o = LW;
        1: o = SW;
        2: o = RT;
        3: o = IT;
        4: o = BR;
        5: o = JAL;
        6: o = 7'b0000000;
        default: o = 7'($urandom);
      endcase
      set_ins(o, 3'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      zero  = 1'($urandom);
      lt    = 1'($urandom);
      ltu   = 1'($urandom);
      stall = ($urandom_range(0, 4) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      settle_check();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
